mmp_iddmm_carry_chain: RTL and testbench

Word-serial carry-propagation controller that sits around mmp_iddmm_addend. It drives the addend's a/b/c operands and consumes its 257-bit d result. For each incoming pair of 256-bit partial-product words it computes carry + b + c. It emits the low 128 bits as a result word and feeds the high 129 bits back as the next carry. After N words it flushes the final carry, producing the complete (N+1)-word IDDMM intermediate sum for the downstream Montgomery stage.

---
 rtl/mmp_iddmm_carry_chain.sv | 169 ++++++++++++++++
 tb/tb_mmp_iddmm_carry_chain.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmp_iddmm_carry_chain.sv
// Word-serial carry chain around mmp_iddmm_addend: carry + b + c per word pair,
// emits low 128 bits per word and flushes the final 129-bit carry as the last word.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, num_words launch an operation of N word pairs (ignored while busy)
//   in_valid/in_ready/b_in/c_in  word-pair input handshake
//   add_a/add_b/add_c/add_d      operand and result bus of the attached addend
//   out_valid/out_word/out_last/carry_out  result beats, LS word first
//   busy, done       operation status, done pulses after the last beat
module mmp_iddmm_carry_chain #(
  parameter int ADD_LATENCY = 0,
  parameter int WCNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WCNT_W-1:0] num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [255:0]      b_in,
  input  logic [255:0]      c_in,
  output logic [128:0]      add_a,
  output logic [255:0]      add_b,
  output logic [255:0]      add_c,
  input  logic [256:0]      add_d,
  output logic              out_valid,
  output logic [127:0]      out_word,
  output logic              out_last,
  output logic              carry_out,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W =
    (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT = LAT_W'(ADD_LATENCY);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FLUSH,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] n_q, n_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [WCNT_W-1:0] wcnt_inc;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [128:0]      carry_q, carry_d;
  logic [255:0]      b_q, b_d;
  logic [255:0]      c_q, c_d;
  logic [127:0]      ow_q, ow_d;
  logic              ov_q, ov_d;
  logic              ol_q, ol_d;
  logic              co_q, co_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  assign wcnt_inc = wcnt_q + WCNT_W'(1);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    lat_d   = lat_q;
    carry_d = carry_q;
    b_d     = b_q;
    c_d     = c_q;
    ow_d    = ow_q;
    ov_d    = 1'b0;
    ol_d    = ol_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = num_words;
          wcnt_d  = '0;
          carry_d = '0;
          busy_d  = 1'b1;
          state_d = (num_words == '0) ? FLUSH : ISSUE;
        end
      end
      ISSUE: begin
        if (in_valid) begin
          b_d     = b_in;
          c_d     = c_in;
          lat_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // lat_q reaches zero in the cycle add_d reflects the held operands
        if (lat_q == '0) begin
          carry_d = add_d[256:128];
          ow_d    = add_d[127:0];
          ov_d    = 1'b1;
          wcnt_d  = wcnt_inc;
          state_d = (wcnt_inc == n_q) ? FLUSH : ISSUE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      FLUSH: begin
        ow_d    = carry_q[127:0];
        co_d    = carry_q[128];
        ol_d    = 1'b1;
        ov_d    = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ol_d    = 1'b0;
        co_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      lat_q   <= '0;
      carry_q <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ow_q    <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      lat_q   <= lat_d;
      carry_q <= carry_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ow_q    <= ow_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == ISSUE);
  assign add_a     = carry_q;
  assign add_b     = b_q;
  assign add_c     = c_q;
  assign out_valid = ov_q;
  assign out_word  = ow_q;
  assign out_last  = ol_q;
  assign carry_out = co_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mmp_iddmm_carry_chain.sv
// Bench for mmp_iddmm_carry_chain: one instance with a combinational addend,
// one with a 2-stage addend; sel steers stimulus and observation.
module tb_mmp_iddmm_carry_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, sel;
  logic [5:0] num_words;
  logic [255:0] b_in, c_in;

  logic s0, v0, r0, ov0, ol0, co0, bs0, dn0;
  logic s2, v2, r2, ov2, ol2, co2, bs2, dn2;
  logic [128:0] a0, a2;
  logic [255:0] ab0, ac0, ab2, ac2;
  logic [256:0] d0, d2, p1, p2;
  logic [127:0] ow0, ow2;

  assign s0 = start & ~sel;
  assign v0 = in_valid & ~sel;
  assign s2 = start & sel;
  assign v2 = in_valid & sel;

  assign d0 = {128'b0, a0} + {1'b0, ab0} + {1'b0, ac0};
  always @(posedge clk) begin
    p1 <= {128'b0, a2} + {1'b0, ab2} + {1'b0, ac2};
    p2 <= p1;
  end
  assign d2 = p2;

  mmp_iddmm_carry_chain #(.ADD_LATENCY(0), .WCNT_W(6)) u0 (
    .clk(clk), .rst(rst), .start(s0), .num_words(num_words),
    .in_valid(v0), .in_ready(r0), .b_in(b_in), .c_in(c_in),
    .add_a(a0), .add_b(ab0), .add_c(ac0), .add_d(d0),
    .out_valid(ov0), .out_word(ow0), .out_last(ol0),
    .carry_out(co0), .busy(bs0), .done(dn0));

  mmp_iddmm_carry_chain #(.ADD_LATENCY(2), .WCNT_W(6)) u2 (
    .clk(clk), .rst(rst), .start(s2), .num_words(num_words),
    .in_valid(v2), .in_ready(r2), .b_in(b_in), .c_in(c_in),
    .add_a(a2), .add_b(ab2), .add_c(ac2), .add_d(d2),
    .out_valid(ov2), .out_word(ow2), .out_last(ol2),
    .carry_out(co2), .busy(bs2), .done(dn2));

  logic rdy, ov, ol, co, bsy, dn;
  logic [127:0] ow;
  logic [128:0] aa;
  logic [255:0] ab, ac;
  assign rdy = sel ? r2 : r0;
  assign ov  = sel ? ov2 : ov0;
  assign ol  = sel ? ol2 : ol0;
  assign co  = sel ? co2 : co0;
  assign bsy = sel ? bs2 : bs0;
  assign dn  = sel ? dn2 : dn0;
  assign ow  = sel ? ow2 : ow0;
  assign aa  = sel ? a2 : a0;
  assign ab  = sel ? ab2 : ab0;
  assign ac  = sel ? ac2 : ac0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] bw[$];
  bit bl[$], bc[$];
  int bt[$], ht[$];
  int rdy_cnt = 0, done_cnt = 0, done_t = 0;

  always @(negedge clk) begin
    if (ov) begin
      bw.push_back(ow);
      bl.push_back(ol);
      bc.push_back(co);
      bt.push_back(cyc);
    end
    if (dn) begin
      done_cnt++;
      done_t = cyc;
    end
    if (rdy) rdy_cnt++;
    if (rdy && in_valid) ht.push_back(cyc);
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic [255:0] sb[16], sc[16];
  logic [127:0] ew[17];
  logic eco;

  function automatic void model(input int n);
    logic [128:0] cr;
    logic [256:0] s;
    cr = '0;
    for (int i = 0; i < n; i++) begin
      s = {128'b0, cr} + {1'b0, sb[i]} + {1'b0, sc[i]};
      ew[i] = s[127:0];
      cr = s[256:128];
    end
    ew[n] = cr[127:0];
    eco = cr[128];
  endfunction

  task automatic clear_mon();
    bw.delete(); bl.delete(); bc.delete();
    bt.delete(); ht.delete();
    rdy_cnt = 0;
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) begin
        sb[i][w*32 +: 32] = $urandom();
        sc[i][w*32 +: 32] = $urandom();
      end
      sb[i][255] = 1'b0;
      sc[i][255] = 1'b0;
    end
  endtask

  task automatic run_op(input int n, input bit hold, input bit poke);
    int idx, k, dc;
    bit hs;
    clear_mon();
    dc = done_cnt;
    start = 1'b1;
    num_words = 6'(n);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    k = 0;
    while (k < 400 && done_cnt == dc) begin
      in_valid = hold || (idx < n);
      b_in = (idx < n) ? sb[idx % 16] : {8{32'hdead_beef}};
      c_in = (idx < n) ? sc[idx % 16] : {8{32'hcafe_f00d}};
      if (poke && (k == 6 || k == 20)) begin
        start = 1'b1;
        num_words = 6'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = in_valid && rdy;
      @(posedge clk); #1;
      if (hs) idx++;
      k++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (done_cnt == dc) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: no done after %0d cycles", k);
    end
  endtask

  task automatic check_op(input string tag, input int n, input int lat);
    int nb;
    nb = bw.size();
    chk({tag, " beats"}, 256'(nb), 256'(n + 1));
    for (int i = 0; i < nb && i <= n; i++) begin
      chk($sformatf("%s word%0d", tag, i), 256'(bw[i]), 256'(ew[i]));
      chk($sformatf("%s last%0d", tag, i), 256'(bl[i]),
          256'(i == n));
    end
    if (nb > 0) begin
      chk({tag, " carry_out"}, 256'(bc[nb-1]), 256'(eco));
      chk({tag, " done_t"}, 256'(done_t), 256'(bt[nb-1] + 1));
    end
    chk({tag, " hs_cnt"}, 256'(ht.size()), 256'(n));
    for (int i = 0; i < ht.size() && i < nb; i++)
      chk($sformatf("%s lat%0d", tag, i), 256'(bt[i] - ht[i]),
          256'(lat + 2));
    for (int i = 1; i < ht.size(); i++)
      chk($sformatf("%s gap%0d", tag, i), 256'(ht[i] - ht[i-1]),
          256'(lat + 2));
    if (n == 0) chk({tag, " no_ready"}, 256'(rdy_cnt), 256'(0));
    @(negedge clk);
    chk({tag, " idle_busy"}, 256'(bsy), 256'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, 256'(ov), 256'(0));
    chk({tag, " out_word"}, 256'(ow), 256'(0));
    chk({tag, " out_last"}, 256'(ol), 256'(0));
    chk({tag, " carry_out"}, 256'(co), 256'(0));
    chk({tag, " busy"}, 256'(bsy), 256'(0));
    chk({tag, " done"}, 256'(dn), 256'(0));
    chk({tag, " in_ready"}, 256'(rdy), 256'(0));
    chk({tag, " add_a"}, 256'(aa), 256'(0));
    chk({tag, " add_b"}, ab, 256'(0));
    chk({tag, " add_c"}, ac, 256'(0));
  endtask

  typedef struct {
    int n;
    logic [255:0] b0, c0, b1, c1;
    logic [127:0] w0, w1, w2;
    bit co;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{1, '1, '1, '0, '0,
              {{127{1'b1}}, 1'b0}, '1, '0, 1'b1};
    tv[1] = '{2, '1, '1, '0, '0,
              {{127{1'b1}}, 1'b0}, '1, 128'd1, 1'b0};
    tv[2] = '{0, '0, '0, '0, '0, '0, '0, '0, 1'b0};
    tv[3] = '{1, 256'd5, 256'd7, '0, '0,
              128'd12, '0, '0, 1'b0};
    tv[4] = '{2, {128'd1, 128'd0}, 256'd3,
              {1'b1, 255'b0}, {1'b1, 255'b0},
              128'd3, 128'd1, 128'd0, 1'b1};
    tv[5] = '{1, {128'd1, {128{1'b1}}}, 256'd1, '0, '0,
              128'd0, 128'd2, '0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    sel = 1'b0;
    num_words = '0;
    b_in = '0;
    c_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst_l0");
    sel = 1'b1;
    #1;
    chk_zero("rst_l2");
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      sb[0] = tv[i].b0; sc[0] = tv[i].c0;
      sb[1] = tv[i].b1; sc[1] = tv[i].c1;
      ew[0] = tv[i].w0; ew[1] = tv[i].w1; ew[2] = tv[i].w2;
      eco = tv[i].co;
      run_op(tv[i].n, i[0], 1'b0);
      check_op($sformatf("vec%0d", i), tv[i].n, 0);
    end

    rand_words(5);
    model(5);
    run_op(5, 1'b1, 1'b0);
    check_op("rnd_l0", 5, 0);

    sel = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      rand_words(8);
      model(8);
      run_op(8, 1'b1, 1'b0);
      check_op($sformatf("rnd_l2_%0d", r), 8, 2);
    end

    rand_words(8);
    model(8);
    run_op(8, 1'b1, 1'b1);
    check_op("ignore", 8, 2);

    // abort during WAIT of word 3
    rand_words(8);
    clear_mon();
    start = 1'b1;
    num_words = 6'd8;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    b_in = sb[0];
    c_in = sc[0];
    for (int k = 0; k < 100 && ht.size() < 4; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
      b_in = sb[ht.size() % 16];
      c_in = sc[ht.size() % 16];
    end
    chk("abort hs_reached", 256'(ht.size()), 256'(4));
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    @(negedge clk);
    chk_zero("abort");
    repeat (8) @(posedge clk);
    chk("abort no_beats", 256'(bw.size()), 256'(0));
    @(posedge clk); #1;
    model(8);
    run_op(8, 1'b1, 1'b0);
    check_op("after_abort", 8, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
